// File: rtl/ps2_scancode_fifo.sv
// Elastic scancode buffer between the PS/2 receiver and the keyboard decoder.
// Bytes are queued in a circular buffer and replayed as paced one-cycle strobes.
module ps2_scancode_fifo #(
  parameter int unsigned depth = 8,
  parameter int unsigned gap   = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_trigger,
  input  logic [7:0]               in_byte,
  output logic                     out_trigger,
  output logic [7:0]               out_byte,
  input  logic                     flush,
  input  logic                     ovf_clear,
  output logic                     overflow,
  output logic [$clog2(depth):0]   level
);

  localparam int unsigned AW = $clog2(depth);
  localparam logic [AW:0] Full    = (AW+1)'(depth);
  localparam logic [15:0] GapLoad = 16'(gap - 1);

  typedef enum logic {StIdle, StWait} pacer_e;

  logic [7:0]    mem [depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [15:0]   gap_cnt_q;
  pacer_e        state_q;
  logic          pop, push, drop;

  // A pop in the same cycle frees a slot, so a push into a full buffer still lands.
  always_comb begin
    pop  = (state_q == StIdle) && (count_q != '0) && !flush;
    push = in_trigger && !flush && ((count_q != Full) || pop);
    drop = in_trigger && !flush && (count_q == Full) && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      gap_cnt_q   <= '0;
      state_q     <= StIdle;
      out_trigger <= 1'b0;
      out_byte    <= 8'h00;
      overflow    <= 1'b0;
    end else begin
      out_trigger <= pop;

      if (flush) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        gap_cnt_q <= '0;
        state_q   <= StIdle;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          out_byte <= mem[rd_ptr_q];
        end
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (pop && !push) count_q <= count_q - 1'b1;

        unique case (state_q)
          StIdle: begin
            if (pop) begin
              gap_cnt_q <= GapLoad;
              state_q   <= StWait;
            end
          end
          StWait: begin
            gap_cnt_q <= gap_cnt_q - 16'd1;
            if (gap_cnt_q == 16'd1) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end

      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

  assign level = count_q;

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Randomised and directed bench for ps2_scancode_fifo against a queue-based
// cycle model of the buffer, pacer, flush and overflow rules.
module tb_ps2_scancode_fifo;

  localparam int unsigned Depth = 8;
  localparam int unsigned Gap   = 64;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_trigger, flush, ovf_clear;
  logic [7:0] in_byte;
  logic       out_trigger, overflow;
  logic [7:0] out_byte;
  logic [3:0] level;

  ps2_scancode_fifo #(.depth(Depth), .gap(Gap)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_trigger  (in_trigger),
    .in_byte     (in_byte),
    .out_trigger (out_trigger),
    .out_byte    (out_byte),
    .flush       (flush),
    .ovf_clear   (ovf_clear),
    .overflow    (overflow),
    .level       (level)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: queue of stored bytes plus cycles left before the next pop.
  logic [7:0] q[$];
  int         wait_cnt;
  logic       m_trig;
  logic [7:0] m_byte;
  logic       m_ovf;

  int         pulses[$];
  logic [7:0] pulse_bytes[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wait_cnt = 0;
    m_trig   = 1'b0;
    m_byte   = 8'h00;
    m_ovf    = 1'b0;
  endtask

  task automatic step(input logic trig, input logic [7:0] b, input logic fl, input logic clr);
    logic set_ovf;
    in_trigger = trig;
    in_byte    = b;
    flush      = fl;
    ovf_clear  = clr;
    @(posedge clk);
    set_ovf = 1'b0;
    if (fl) begin
      q.delete();
      wait_cnt = 0;
      m_trig   = 1'b0;
    end else begin
      if (wait_cnt == 0 && q.size() > 0) begin
        m_byte   = q.pop_front();
        m_trig   = 1'b1;
        wait_cnt = Gap - 1;
      end else begin
        m_trig = 1'b0;
        if (wait_cnt > 0) wait_cnt--;
      end
      if (trig) begin
        if (q.size() < Depth) q.push_back(b);
        else set_ovf = 1'b1;
      end
    end
    if (set_ovf) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(negedge clk);
    cyc++;
    check("out_trigger", 32'(out_trigger), 32'(m_trig));
    check("out_byte", 32'(out_byte), 32'(m_byte));
    check("level", 32'(level), 32'(q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (out_trigger) begin
      pulses.push_back(cyc);
      pulse_bytes.push_back(out_byte);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || wait_cnt != 0) && n < 2000) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    check("idle_timeout", 32'(n < 2000), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_trig"}, 32'(out_trigger), 32'd0);
    check({tag, "_byte"}, 32'(out_byte), 32'h00);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
  endtask

  initial begin
    int n;
    int t0;
    reset_n    = 1'b0;
    in_trigger = 1'b0;
    in_byte    = 8'h00;
    flush      = 1'b0;
    ovf_clear  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    cyc     = 0;

    // Single byte: two-cycle latency, level visible for one cycle.
    while (cyc < 10) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    check("single_lvl11", 32'(level), 32'd1);
    check("single_trig11", 32'(out_trigger), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("single_trig12", 32'(out_trigger), 32'd1);
    check("single_byte12", 32'(out_byte), 32'hF0);
    check("single_lvl12", 32'(level), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("single_trig13", 32'(out_trigger), 32'd0);
    wait_idle();

    // Burst pacing: pulses exactly Gap apart.
    pulses.delete();
    pulse_bytes.delete();
    t0 = cyc;
    step(1'b1, 8'hE0, 1'b0, 1'b0);
    step(1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    step(1'b1, 8'h12, 1'b0, 1'b0);
    wait_idle();
    idle(2);
    check("burst_count", 32'(pulses.size()), 32'd4);
    if (pulses.size() == 4) begin
      check("burst_first", 32'(pulses[0] - t0), 32'd2);
      for (int i = 1; i < 4; i++) check("burst_space", 32'(pulses[i] - pulses[i-1]), Gap);
      check("burst_b0", 32'(pulse_bytes[0]), 32'hE0);
      check("burst_b1", 32'(pulse_bytes[1]), 32'h12);
      check("burst_b2", 32'(pulse_bytes[2]), 32'hF0);
      check("burst_b3", 32'(pulse_bytes[3]), 32'h12);
    end
    check("burst_ovf", 32'(overflow), 32'd0);

    // Overflow: 01 pops at once, 02..09 fill the buffer, 0A is dropped.
    pulses.delete();
    pulse_bytes.delete();
    for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clear", 32'(overflow), 32'd0);

    // Full buffer, push in the same cycle as a pop.
    n = 0;
    while (!(wait_cnt == 0 && q.size() == Depth) && n < 200) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    check("fullpop_timeout", 32'(n < 200), 32'd1);
    step(1'b1, 8'hB1, 1'b0, 1'b0);
    check("fullpop_level", 32'(level), 32'd8);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    check("fullpop_trig", 32'(out_trigger), 32'd1);
    wait_idle();
    idle(2);
    check("replay_count", 32'(pulses.size()), 32'd10);
    if (pulses.size() == 10) begin
      for (int i = 0; i < 9; i++) check("replay_byte", 32'(pulse_bytes[i]), 32'(i + 1));
      check("replay_b1", 32'(pulse_bytes[9]), 32'hB1);
    end

    // Flush with a same-cycle push; overflow survives the flush.
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    n = 0;
    while (q.size() != 5 && n < 400) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      n++;
    end
    check("flush_timeout", 32'(n < 400), 32'd1);
    check("flush_pre_level", 32'(level), 32'd5);
    pulses.delete();
    pulse_bytes.delete();
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    check("flush_level", 32'(level), 32'd0);
    check("flush_trig", 32'(out_trigger), 32'd0);
    check("flush_ovf", 32'(overflow), 32'd1);
    idle(100);
    check("flush_no_pulse", 32'(pulses.size()), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clear_after_flush", 32'(overflow), 32'd0);

    // Asynchronous reset while three bytes are queued.
    wait_idle();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    check("mid_level", 32'(level), 32'd3);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async");
    model_reset();
    @(negedge clk);
    check_reset_values("held");
    reset_n = 1'b1;
    step(1'b1, 8'h1C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_trig", 32'(out_trigger), 32'd1);
    check("rst_byte", 32'(out_byte), 32'h1C);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 19) == 0), 8'($urandom), ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_fifo.md
# ps2_scancode_fifo

Elastic buffer between the PS/2 receiver (`ps2com`) and the PS/2 keyboard decoder (`keyboard_ps2`) on the board top levels. It accepts one-cycle `recv_trigger`/`recv_byte` strobes from the receiver and stores them in a small FIFO. It replays them to the decoder as one-cycle `trigger`/`scancode` strobes, with a guaranteed minimum spacing between strobes. Bytes that arrive while the FIFO is full are reported through a sticky overflow flag, and the FIFO can be flushed when the service processor resynchronises the keyboard.

## Interface
Parameters:
- `depth`, 8: number of FIFO entries; power of two, 2 to 64.
- `gap`, 64: minimum number of `clk` cycles between consecutive `out_trigger` pulses; range 2 to 65535.

Ports:
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `in_trigger`, in, 1: one-cycle strobe from `ps2com`; a new byte is valid this cycle.
- `in_byte`, in, 8: scancode byte; sampled only when `in_trigger` is high.
- `out_trigger`, out, 1: one-cycle strobe to `keyboard_ps2`.
- `out_byte`, out, 8: scancode byte; valid while `out_trigger` is high and held until the next pulse.
- `flush`, in, 1: synchronous clear of FIFO contents and of the pacer.
- `ovf_clear`, in, 1: clears the sticky `overflow` flag.
- `overflow`, out, 1: sticky flag; set when a byte is dropped because the FIFO is full.
- `level`, out, log2(depth)+1: current number of stored entries, 0 to depth.

## Operation
- Storage:
  - Circular buffer with `depth` entries.
  - Write and read pointers are log2(depth) bits wide and wrap modulo `depth`.
  - A separate occupancy counter drives `level`.
- Write: on `in_trigger` with pre-edge `level` < `depth`, store `in_byte` and advance the write pointer.
- Full drop: on `in_trigger` with `level` == `depth`, discard the byte and set `overflow`, unless a pop occurs in the same cycle (see below).
- Pacer states:
  - IDLE: the gap counter is zero. If `level` > 0, issue a pop.
  - WAIT: the gap counter is non-zero and decrements by 1 per cycle. No pop is issued.
- Pop:
  - Registers the head entry into `out_byte`, pulses `out_trigger` for one cycle on the next edge, and advances the read pointer.
  - Loads the gap counter with `gap`-1 in the same cycle.
- Simultaneous push and pop: `level` is unchanged.
  - When full, the push is accepted because the pop frees a slot in the same edge.
  - `overflow` is not set in that case.
- Empty: no pop is issued and `out_trigger` stays low. `out_byte` retains its last value.
- Flush:
  - Write pointer, read pointer and `level` go to 0, and the pacer returns to IDLE.
  - A same-cycle `in_trigger` byte is discarded.
  - A pop decision made in the same cycle is cancelled, so no `out_trigger` follows.
  - `overflow` is unaffected.
- Overflow flag: set has priority over `ovf_clear` in the same cycle.
- Arithmetic: all pointer and counter arithmetic is unsigned and modulo its width. The gap counter is 16 bits.

## Timing
- Reset values (while `reset_n` is low, and immediately on assertion, asynchronously):
  - `out_trigger`=0, `out_byte`=8'h00, `overflow`=0, `level`=0.
  - Pointers = 0, pacer = IDLE.
- Latency: with the FIFO empty and the pacer IDLE, `in_trigger` in cycle n gives `out_trigger` in cycle n+2, carrying that byte.
  - Cycle n+1: `level`=1, pop decided.
  - Cycle n+2: pulse, `level` back to 0.
- Spacing: with the FIFO continuously non-empty, `out_trigger` pulses occur exactly `gap` cycles apart (at t, t+gap, ...).
- `level` updates one edge after the event that changes it. `overflow` rises one edge after the dropped `in_trigger`.
- `out_trigger` is never high for two consecutive cycles.
- Mid-operation `reset_n` assertion: all state is lost. After release, the first accepted byte behaves as in the empty-FIFO latency case.

## Test plan
- Single byte:
  - Stimulus: after reset, pulse `in_trigger` with 8'hF0 in cycle 10.
  - Required: `out_trigger` high in cycle 12 only, `out_byte`=8'hF0, `level` reads 1 in cycle 11 and 0 from cycle 12.
- Burst pacing:
  - Stimulus: `gap`=64, `depth`=8; push 8'hE0, 8'h12, 8'hF0, 8'h12 on consecutive cycles.
  - Required: four `out_trigger` pulses exactly 64 cycles apart, in order, with the correct bytes; `overflow` stays 0.
- Overflow:
  - Stimulus: `depth`=8, `gap`=1000; push 10 bytes 8'h01 to 8'h0A back to back.
  - Required:
    - 8'h01 is popped immediately.
    - 8'h02 to 8'h09 are stored (`level`=8) and 8'h0A is dropped.
    - `overflow`=1.
    - The outputs replay 8'h01 to 8'h09 in order.
- Full with simultaneous pop:
  - Stimulus: FIFO full; `in_trigger` lands in the same cycle as a pop.
  - Required: the byte is accepted, `level` stays 8 and `overflow` stays 0.
- Flush and clear:
  - Stimulus: `level`=5; assert `flush` together with `in_trigger` (8'hAA); later assert `ovf_clear` while `overflow`=1.
  - Required:
    - After the flush: `level`=0, no `out_trigger` and 8'hAA is never output.
    - `overflow` holds through the flush and drops one cycle after `ovf_clear`.
- Reset mid-burst:
  - Stimulus: drop `reset_n` asynchronously mid-cycle while `level`=3.
  - Required: all outputs are at their reset values immediately. After release, a push of 8'h1C appears on `out_trigger` two cycles later.
